// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs RV32I instruction fields and a 32-bit immediate
// into an instruction word, range-checks the immediate, and streams the
// encoded words into instruction memory at an auto-incrementing address.
module imm_instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-2:0] count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, RUN, FULL, ERR} state_t;

    typedef enum logic [2:0] {
        T_R = 3'b000,
        T_I = 3'b001,
        T_S = 3'b010,
        T_B = 3'b011,
        T_U = 3'b100,
        T_J = 3'b101
    } fmt_t;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_RANGE = 2'b01;
    localparam logic [1:0] E_ALIGN = 2'b10;
    localparam logic [1:0] E_TYPE  = 2'b11;

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    state_t            state, state_next;
    logic [31:0]       enc_word;
    logic [1:0]        enc_code;
    logic              commit;
    logic              accept;
    logic              room;
    logic [ADDR_W-1:0] count_ext;
    logic [ADDR_W-1:0] count_inc;

    assign commit    = mem_we && mem_ready;
    assign count_ext = {1'b0, count};
    assign count_inc = count_ext + 1'b1;
    // Words committed plus the one still pending must stay below DEPTH to accept another.
    assign room      = (count_ext + {{(ADDR_W-1){1'b0}}, mem_we}) < DEPTH_W;
    assign in_ready  = (state == RUN) && (!mem_we || mem_ready) && room;
    assign accept    = in_valid && in_ready && !start;
    assign done      = (state == FULL);
    assign err       = (state == ERR);

    // Scatter immediate bits per format and classify the immediate.
    always_comb begin
        enc_word = '0;
        enc_code = E_NONE;
        case (in_type)
            T_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            T_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                if (!(&in_imm[31:11] || ~|in_imm[31:11])) enc_code = E_RANGE;
            end
            T_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                if (!(&in_imm[31:11] || ~|in_imm[31:11])) enc_code = E_RANGE;
            end
            T_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                if (in_imm[0]) enc_code = E_ALIGN;
                else if (!(&in_imm[31:12] || ~|in_imm[31:12])) enc_code = E_RANGE;
            end
            T_U: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                if (|in_imm[11:0]) enc_code = E_RANGE;
            end
            T_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                if (in_imm[0]) enc_code = E_ALIGN;
                else if (!(&in_imm[31:20] || ~|in_imm[31:20])) enc_code = E_RANGE;
            end
            default: enc_code = E_TYPE;
        endcase
    end

    // Next-state logic; start overrides everything and re-enters RUN.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (commit && count_inc == DEPTH_W) state_next = FULL;
                else if (accept && enc_code != E_NONE) state_next = ERR;
            end
            default: state_next = state;
        endcase
        if (start) state_next = RUN;
    end

    // State register plus write-port datapath (address, data, strobe, counters).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err_code  <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                mem_addr <= {base_addr[ADDR_W-1:2], 2'b00};
                count    <= '0;
                err_code <= '0;
                mem_we   <= 1'b0;
            end else begin
                if (commit) begin
                    mem_addr <= mem_addr + ADDR_W'(4);
                    count    <= count + 1'b1;
                end
                if (accept && enc_code == E_NONE) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc_word;
                end else if (commit) begin
                    mem_we <= 1'b0;
                end
                if (accept && enc_code != E_NONE) err_code <= enc_code;
            end
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed testbench for imm_instr_encoder (DEPTH=4 build so the full/wrap
// behaviour is reachable in a few cycles).
module tb_imm_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int vectors = 0;
    int miscompares = 0;

    imm_instr_encoder #(.ADDR_W(10), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .done(done), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic pulse_start(input logic [9:0] base);
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; base_addr = '0;
        set_fields(3'b001, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step(); step();
        rst = 1'b0;
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL reset_we got %b want 0", mem_we); miscompares++; end
        vectors++; if (in_ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", in_ready); miscompares++; end
        vectors++; if ({done, err} !== 2'b00) begin $display("FAIL reset_done_err got %b want 00", {done, err}); miscompares++; end
        vectors++; if (mem_addr !== 10'h000 || count !== 9'd0) begin $display("FAIL reset_addr_count got %h/%0d want 000/0", mem_addr, count); miscompares++; end
        vectors++; if (mem_wdata !== 32'h0 || err_code !== 2'b00) begin $display("FAIL reset_wdata_code got %h/%b want 0/00", mem_wdata, err_code); miscompares++; end
    endtask

    task automatic test_addi();
        pulse_start(10'h040);
        mem_ready = 1'b1;
        set_fields(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin $display("FAIL addi_ready got %b want 1", in_ready); miscompares++; end
        step();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 10'h040) begin $display("FAIL addi_write got we=%b addr=%h want 1/040", mem_we, mem_addr); miscompares++; end
        vectors++; if (mem_wdata !== 32'h00500093) begin $display("FAIL addi_word got %h want 00500093", mem_wdata); miscompares++; end
        step();
        vectors++; if (count !== 9'd1 || mem_we !== 1'b0 || mem_addr !== 10'h044) begin $display("FAIL addi_commit got cnt=%0d we=%b addr=%h want 1/0/044", count, mem_we, mem_addr); miscompares++; end
    endtask

    task automatic test_back_to_back();
        pulse_start(10'h040);
        mem_ready = 1'b1;
        set_fields(3'b010, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        in_valid = 1'b1;
        step();
        set_fields(3'b011, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        vectors++; if (mem_wdata !== 32'h0020A423 || mem_addr !== 10'h040) begin $display("FAIL sw_word got %h@%h want 0020A423@040", mem_wdata, mem_addr); miscompares++; end
        vectors++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready got %b want 1", in_ready); miscompares++; end
        step();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'hFE208EE3 || mem_addr !== 10'h044) begin $display("FAIL beq_word got we=%b %h@%h want 1 FE208EE3@044", mem_we, mem_wdata, mem_addr); miscompares++; end
        vectors++; if (count !== 9'd1) begin $display("FAIL b2b_count1 got %0d want 1", count); miscompares++; end
        step();
        vectors++; if (count !== 9'd2 || mem_we !== 1'b0) begin $display("FAIL b2b_count2 got cnt=%0d we=%b want 2/0", count, mem_we); miscompares++; end
    endtask

    task automatic test_misc_formats();
        pulse_start(10'h200);
        mem_ready = 1'b1;
        // sub x3,x1,x2 with a junk immediate that R must ignore
        set_fields(3'b000, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
        in_valid = 1'b1;
        step();
        // lui x5,0x12345
        set_fields(3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        vectors++; if (mem_wdata !== 32'h402081B3) begin $display("FAIL r_word got %h want 402081B3", mem_wdata); miscompares++; end
        step();
        in_valid = 1'b0;
        vectors++; if (mem_wdata !== 32'h123452B7 || mem_addr !== 10'h204) begin $display("FAIL u_word got %h@%h want 123452B7@204", mem_wdata, mem_addr); miscompares++; end
        step();
    endtask

    task automatic test_stall();
        pulse_start(10'h100);
        mem_ready = 1'b0;
        set_fields(3'b101, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'h001000EF || mem_addr !== 10'h100) begin $display("FAIL stall_hold%0d got we=%b %h@%h want 1 001000EF@100", i, mem_we, mem_wdata, mem_addr); miscompares++; end
            vectors++; if (in_ready !== 1'b0 || count !== 9'd0) begin $display("FAIL stall_ready%0d got rdy=%b cnt=%0d want 0/0", i, in_ready, count); miscompares++; end
            step();
        end
        mem_ready = 1'b1;
        step();
        vectors++; if (count !== 9'd1 || mem_we !== 1'b0 || mem_addr !== 10'h104) begin $display("FAIL stall_commit got cnt=%0d we=%b addr=%h want 1/0/104", count, mem_we, mem_addr); miscompares++; end
    endtask

    task automatic test_errors();
        pulse_start(10'h000);
        mem_ready = 1'b1;
        set_fields(3'b011, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b10 || in_ready !== 1'b0) begin $display("FAIL b_misalign got we=%b err=%b code=%b rdy=%b want 0/1/10/0", mem_we, err, err_code, in_ready); miscompares++; end
        pulse_start(10'h000);
        vectors++; if (err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b1) begin $display("FAIL start_clears got err=%b code=%b rdy=%b want 0/00/1", err, err_code, in_ready); miscompares++; end
        set_fields(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (err !== 1'b1 || err_code !== 2'b01 || mem_we !== 1'b0) begin $display("FAIL i_range got err=%b code=%b we=%b want 1/01/0", err, err_code, mem_we); miscompares++; end
        pulse_start(10'h000);
        set_fields(3'b111, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (err !== 1'b1 || err_code !== 2'b11) begin $display("FAIL bad_type got err=%b code=%b want 1/11", err, err_code); miscompares++; end
        // odd and out of range: misalignment code wins
        pulse_start(10'h000);
        set_fields(3'b011, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_1001);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (err_code !== 2'b10) begin $display("FAIL align_wins got code=%b want 10", err_code); miscompares++; end
        pulse_start(10'h000);
        set_fields(3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1004);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (err_code !== 2'b01) begin $display("FAIL u_lowbits got code=%b want 01", err_code); miscompares++; end
        // pending write still commits when the next input is rejected
        pulse_start(10'h020);
        set_fields(3'b010, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        in_valid = 1'b1;
        step();
        set_fields(3'b101, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        step();
        in_valid = 1'b0;
        vectors++; if (count !== 9'd1 || mem_we !== 1'b0 || err_code !== 2'b01 || mem_addr !== 10'h024) begin $display("FAIL err_pending got cnt=%0d we=%b code=%b addr=%h want 1/0/01/024", count, mem_we, err_code, mem_addr); miscompares++; end
    endtask

    task automatic test_full_wrap();
        int commits;
        commits = 0;
        pulse_start(10'h3FC);
        mem_ready = 1'b1;
        set_fields(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (mem_we && mem_ready) commits++;
            step();
            if (i == 1) begin
                vectors++; if (mem_addr !== 10'h000 || mem_we !== 1'b1) begin $display("FAIL wrap_addr got we=%b addr=%h want 1/000", mem_we, mem_addr); miscompares++; end
            end
        end
        in_valid = 1'b0;
        vectors++; if (commits !== 4) begin $display("FAIL full_commits got %0d want 4", commits); miscompares++; end
        vectors++; if (done !== 1'b1 || in_ready !== 1'b0 || count !== 9'd4 || mem_we !== 1'b0) begin $display("FAIL full_state got done=%b rdy=%b cnt=%0d we=%b want 1/0/4/0", done, in_ready, count, mem_we); miscompares++; end
        pulse_start(10'h000);
        vectors++; if (done !== 1'b0 || count !== 9'd0) begin $display("FAIL full_restart got done=%b cnt=%0d want 0/0", done, count); miscompares++; end
    endtask

    task automatic test_rst_mid();
        pulse_start(10'h080);
        mem_ready = 1'b0;
        set_fields(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1) begin $display("FAIL rst_pre_we got %b want 1", mem_we); miscompares++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || count !== 9'd0 || mem_addr !== 10'h000) begin $display("FAIL rst_mid got we=%b rdy=%b cnt=%0d addr=%h want 0/0/0/000", mem_we, in_ready, count, mem_addr); miscompares++; end
        mem_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b0 || count !== 9'd0) begin $display("FAIL idle_ignores got we=%b cnt=%0d want 0/0", mem_we, count); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_misc_formats();
        test_stall();
        test_errors();
        test_full_wrap();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register, funct and a 32-bit signed/unsigned immediate into a 32-bit RV32I instruction word.
- Scatters immediate bits per format and range-checks the immediate.
- Streams the encoded words into instruction memory through a write port with an auto-incrementing address.
- Used by the self-test/boot loader to build programs in-system.

Parameters:
- ADDR_W, 10, byte-address width of the instruction memory write port.
- DEPTH, 256, maximum words written per run; must be at least 1 and no more than 2^(ADDR_W-2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: load base_addr, clear count and error, enter RUN.
- base_addr  input  ADDR_W  start byte address, word aligned (bits [1:0] ignored and treated as 0).
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder accepts fields this cycle.
- in_type  input  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J; 110/111 illegal.
- in_opcode  input  7  opcode field, bits [6:0].
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field (R only).
- in_imm  input  32  immediate value, two's complement.
- mem_we  output  1  write strobe; doubles as output-valid.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W-1  words committed this run.
- done  output  1  DEPTH words committed.
- err  output  1  sticky error.
- err_code  output  2  01 immediate out of range, 10 misaligned branch/jump target, 11 illegal type.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - mem_we, in_ready, done and err all go to 0.
  - mem_addr, mem_wdata, count and err_code all go to 0.
- States:
  - IDLE: in_ready=0. start goes to RUN.
  - RUN: in_ready = !mem_we || mem_ready.
  - FULL: in_ready=0, done=1. start goes to RUN.
  - ERR: in_ready=0, err=1. start goes to RUN.
  - In every state, start reloads the address, clears count, done, err and err_code, and drops any pending mem_we.
  - start has priority over a same-cycle in_valid; that input is not accepted.
- Accept: in_valid && in_ready. Encoded word appears on mem_wdata with mem_we=1 the next cycle (latency 1).
- Hold rule: while mem_we=1 and mem_ready=0, mem_addr and mem_wdata stay stable.
- Commit: mem_we && mem_ready.
  - mem_addr advances by 4 after each commit and count increments.
  - A new accept in the commit cycle is legal (back-to-back, one word per clock).
- Wrap and full:
  - mem_addr wraps modulo 2^ADDR_W.
  - When count reaches DEPTH on a commit, go to FULL and drop mem_we.
  - The accept that would become word DEPTH+1 never happens: in_ready=0 once count plus pending equals DEPTH.
- Encoding:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
  - R ignores in_imm.
- Checks (evaluated at accept):
  - I/S: imm[31:11] must be all equal.
  - B: imm[31:12] all equal, and imm[0]=0.
  - U: imm[11:0]=0; otherwise code 01.
  - J: imm[31:20] all equal, and imm[0]=0.
  - Misalignment wins over range: code 10.
- On a failed check:
  - No write is generated; the previous pending write still completes normally.
  - Next cycle: state goes to ERR, err_code is latched and err=1.
- rst mid-run: pending write is discarded, mem_we=0 on the next cycle, state is IDLE.

Test Plan:
- start with base_addr=0x040; I addi (op 0x13, rd=1, rs1=0, f3=0, imm=5) -> next cycle mem_we=1, mem_addr=0x040, mem_wdata=0x00500093; count=1 after commit.
- S sw (op 0x23, rs1=1, rs2=2, f3=2, imm=8), then B beq (op 0x63, rs1=1, rs2=2, f3=0, imm=-4) back-to-back with mem_ready=1 -> 0x0020A423 at 0x040, then 0xFE208EE3 at 0x044.
- J jal (op 0x6F, rd=1, imm=0x800) with mem_ready held 0 for 3 cycles -> mem_wdata=0x001000EF held stable and in_ready=0; commits on the first mem_ready=1.
- B with imm=3 -> no write, err=1, err_code=10. I with imm=2048 after start -> err_code=01. in_type=111 -> err_code=11. start clears err.
- DEPTH=4 build with 6 valid inputs -> exactly 4 commits, done=1, in_ready=0; base_addr=0x3FC -> second word at 0x000.
- rst asserted while mem_we=1 and mem_ready=0 -> mem_we=0 and state IDLE the next cycle, no commit.
